// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: a single full-subtractor cell plus a registered borrow.
// It computes diff = a - b (mod 2^WIDTH) and borrow_out = (a < b).
// busy_o is high from the accepted start until the return to idle.
// done_o pulses for one cycle, WIDTH edges after the start edge.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             borrow_q, borrow_d;

  // Full-subtractor cell on the current LSBs
  logic cell_d;
  logic cell_bor;

  // Next-state logic: bit-cell evaluation, shifting and result capture
  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;

    cell_d   = sh_a_q[0] ^ sh_b_q[0] ^ bor_q;
    cell_bor = (~sh_a_q[0] & sh_b_q[0]) | (~(sh_a_q[0] ^ sh_b_q[0]) & bor_q);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sh_a_d  = a_i;
          sh_b_d  = b_i;
          res_d   = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        bor_d  = cell_bor;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last bit: publish the assembled result together with the final borrow
          diff_d   = {cell_d, res_q[WIDTH-1:1]};
          borrow_d = cell_bor;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign diff_o       = diff_q;
  assign borrow_out_o = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor.
// The driver pushes the expected {borrow, diff} and the done cycle for each accepted request.
// A negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .a_i          (a),
    .b_i          (b),
    .busy_o       (busy),
    .done_o       (done),
    .diff_o       (diff),
    .borrow_out_o (borrow_out)
  );

  always #10 clk = ~clk;

  int   cyc = 0;
  logic rst_edge = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  typedef struct {
    int         cyc;
    logic [W:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: done timing/value, one-cycle done, output hold and reset values
  logic [W:0] held = '0;
  bit         prev_done = 1'b0;
  exp_t       e;
  always @(negedge clk) begin
    if (rst_edge) begin
      held = '0;
      check("reset_busy_done", {62'd0, busy, done}, 64'd0);
      check("reset_result", {55'd0, borrow_out, diff}, 64'd0);
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", {62'd0, busy, done}, 64'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("result", {55'd0, borrow_out, diff}, {55'd0, e.val});
          held = e.val;
        end
      end
      check("result_hold", {55'd0, borrow_out, diff}, {55'd0, held});
      prev_done = done;
    end
  end

  // Issue one request at a negedge once idle; returns at the negedge after the start edge
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push,
                    input bit hold);
    int n = 0;
    while (busy !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        check("idle_timeout", 64'd1, 64'd0);
        return;
      end
    end
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    check("accept_busy", {63'd0, busy}, 64'd1);
    if (push) sb.push_back('{cyc + int'(W), {1'b0, av} - {1'b0, bv}});
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    op(8'h05, 8'h03, 1, 0);
    op(8'h03, 8'h05, 1, 0);
    op(8'h00, 8'h01, 1, 0);
    op(8'hFF, 8'hFF, 1, 0);
    op(8'hA5, 8'h00, 1, 0);

    // Second start while busy must be dropped
    op(8'h10, 8'h01, 1, 0);
    repeat (2) @(negedge clk);
    a     = 8'h00;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset at E4 of a run discards it
    op(8'h33, 8'h11, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_run_reset_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    op(8'h09, 8'h04, 1, 0);

    // start held high: back-to-back accepts
    op(8'h40, 8'h20, 1, 1);
    op(8'h20, 8'h40, 1, 1);
    op(8'h7F, 8'h80, 1, 1);
    start = 1'b0;

    // Randomized pairs, sometimes with start held
    for (int i = 0; i < 1000; i++) begin
      op(W'($urandom), W'($urandom), 1, ($urandom_range(0, 3) == 0));
    end
    start = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
